// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA timing/control block.
// Holds the FSM state encoding, the channel transfer-mode codes and the default channel geometry.
package dma_pkg;

    localparam int DMA_NUM_CH = 4;
    localparam int DMA_CH_W   = 2;

    localparam logic [1:0] MODE_DEMAND  = 2'b00;
    localparam logic [1:0] MODE_SINGLE  = 2'b01;
    localparam logic [1:0] MODE_BLOCK   = 2'b10;
    localparam logic [1:0] MODE_CASCADE = 2'b11;

    typedef enum logic [2:0] {
        SI   = 3'd0,
        S0   = 3'd1,
        S1   = 3'd2,
        S2   = 3'd3,
        S3   = 3'd4,
        S4   = 3'd5,
        CASC = 3'd6
    } state_t;

endpackage

// File: rtl/dma_strobe_decode.sv
// Combinational decode from the timing state to the bus strobes, DACK and AEN.
// The read strobe opens in S3, and the write strobe joins it in S4.
module dma_strobe_decode
    import dma_pkg::*;
#(
    parameter int NUM_CH = DMA_NUM_CH,
    parameter int CH_W   = DMA_CH_W
) (
    input  state_t              state,
    input  logic                isRead,
    input  logic [CH_W-1:0]     svcCh,
    output logic                memr_n,
    output logic                memw_n,
    output logic                ior_n,
    output logic                iow_n,
    output logic [NUM_CH-1:0]   dack,
    output logic                aen
);

    always_comb begin
        memr_n = 1'b1;
        memw_n = 1'b1;
        ior_n  = 1'b1;
        iow_n  = 1'b1;
        dack   = '0;
        aen    = 1'b0;
        case (state)
            S1, S2: begin
                aen         = 1'b1;
                dack[svcCh] = 1'b1;
            end
            S3: begin
                aen         = 1'b1;
                dack[svcCh] = 1'b1;
                memr_n      = ~isRead;
                ior_n       = isRead;
            end
            S4: begin
                aen         = 1'b1;
                dack[svcCh] = 1'b1;
                memr_n      = ~isRead;
                iow_n       = ~isRead;
                ior_n       = isRead;
                memw_n      = isRead;
            end
            // A cascaded slave drives the bus itself; only DACK is given.
            CASC: begin
                dack[svcCh] = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/dma_timing_control.sv
// Master timing FSM of the DMA controller: arbitration latch, HRQ/HLDA handshake and the S0-S4
// active cycle, producing datapath strobes for single, block, demand and cascade transfers.
module dma_timing_control
    import dma_pkg::*;
#(
    parameter int NUM_CH = DMA_NUM_CH,
    parameter int CH_W   = DMA_CH_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   dmaReq,
    input  logic [CH_W-1:0]     channelNo,
    input  logic                hlda,
    input  logic                TC,
    input  logic                carrypresent,
    input  logic [1:0]          transferMode,
    input  logic                isRead,
    output logic                hrq,
    output logic [NUM_CH-1:0]   dack,
    output logic                aen,
    output logic                adstb,
    output logic                memr_n,
    output logic                memw_n,
    output logic                ior_n,
    output logic                iow_n,
    output logic                PriorityGen,
    output logic                ldTempAddr,
    output logic                ldUpperAddress,
    output logic                ldLowerAddress,
    output logic                AddrGen,
    output logic                ldTempRegister,
    output logic                eop_n,
    output logic [CH_W-1:0]     svcCh
);

    state_t            stateReg, stateNext;
    logic [CH_W-1:0]   svcChReg, svcChNext;
    logic              firstReg, firstNext;
    logic              hldaLostReg, hldaLostNext;
    logic              anyReq;
    logic              svcReq;

    assign anyReq = |dmaReq;
    assign svcReq = dmaReq[svcChReg];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg    <= SI;
            svcChReg    <= '0;
            firstReg    <= 1'b0;
            hldaLostReg <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            svcChReg    <= svcChNext;
            firstReg    <= firstNext;
            hldaLostReg <= hldaLostNext;
        end
    end

    always_comb begin
        stateNext      = stateReg;
        svcChNext      = svcChReg;
        firstNext      = firstReg;
        hldaLostNext   = hldaLostReg;
        hrq            = 1'b0;
        PriorityGen    = 1'b0;
        ldTempAddr     = 1'b0;
        ldUpperAddress = 1'b0;
        ldLowerAddress = 1'b0;
        AddrGen        = 1'b0;
        adstb          = 1'b0;
        eop_n          = 1'b1;
        case (stateReg)
            SI: begin
                hldaLostNext = 1'b0;
                if (anyReq) begin
                    // Gated by rst so nothing strobes while reset is held.
                    PriorityGen = rst;
                    svcChNext   = channelNo;
                    firstNext   = 1'b1;
                    stateNext   = S0;
                end
            end
            S0: begin
                hrq = 1'b1;
                if (hlda) begin
                    ldTempAddr = 1'b1;
                    stateNext  = (transferMode == MODE_CASCADE) ? CASC : S1;
                end
            end
            CASC: begin
                hrq = 1'b1;
                if (!svcReq || !hlda) begin
                    stateNext = SI;
                end
            end
            S1: begin
                hrq            = 1'b1;
                ldUpperAddress = 1'b1;
                adstb          = 1'b1;
                firstNext      = 1'b0;
                hldaLostNext   = hldaLostReg | ~hlda;
                stateNext      = S2;
            end
            S2: begin
                hrq            = 1'b1;
                ldLowerAddress = 1'b1;
                hldaLostNext   = hldaLostReg | ~hlda;
                stateNext      = S3;
            end
            S3: begin
                hrq          = 1'b1;
                hldaLostNext = hldaLostReg | ~hlda;
                stateNext    = S4;
            end
            S4: begin
                hrq     = 1'b1;
                AddrGen = 1'b1;
                if (TC) begin
                    eop_n     = 1'b0;
                    stateNext = SI;
                end else if (hldaLostReg || !hlda) begin
                    // Bus was taken back mid-transfer: finish this cycle and let go.
                    stateNext = SI;
                end else begin
                    case (transferMode)
                        MODE_BLOCK:  stateNext = (carrypresent || firstReg) ? S1 : S2;
                        MODE_DEMAND: begin
                            if (svcReq) begin
                                stateNext = (carrypresent || firstReg) ? S1 : S2;
                            end else begin
                                stateNext = SI;
                            end
                        end
                        MODE_SINGLE: stateNext = SI;
                        default:     stateNext = SI;
                    endcase
                end
            end
            default: stateNext = SI;
        endcase
    end

    assign ldTempRegister = 1'b0;
    assign svcCh          = svcChReg;

    dma_strobe_decode #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_strobeDecode (
        .state  (stateReg),
        .isRead (isRead),
        .svcCh  (svcChReg),
        .memr_n (memr_n),
        .memw_n (memw_n),
        .ior_n  (ior_n),
        .iow_n  (iow_n),
        .dack   (dack),
        .aen    (aen)
    );

endmodule

// File: tb/tb_dma_timing_control.sv
// Directed bench for dma_timing_control: table of service scenarios plus cascade and
// asynchronous-reset sequences, with a behavioural CPU/datapath responder.
module tb_dma_timing_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dmaReq;
    logic [1:0] channelNo;
    logic       hlda;
    logic       TC;
    logic       carrypresent;
    logic [1:0] transferMode;
    logic       isRead;
    logic       hrq;
    logic [3:0] dack;
    logic       aen;
    logic       adstb;
    logic       memr_n;
    logic       memw_n;
    logic       ior_n;
    logic       iow_n;
    logic       PriorityGen;
    logic       ldTempAddr;
    logic       ldUpperAddress;
    logic       ldLowerAddress;
    logic       AddrGen;
    logic       ldTempRegister;
    logic       eop_n;
    logic [1:0] svcCh;

    dma_timing_control dut (
        .clk            (clk),
        .rst            (rst),
        .dmaReq         (dmaReq),
        .channelNo      (channelNo),
        .hlda           (hlda),
        .TC             (TC),
        .carrypresent   (carrypresent),
        .transferMode   (transferMode),
        .isRead         (isRead),
        .hrq            (hrq),
        .dack           (dack),
        .aen            (aen),
        .adstb          (adstb),
        .memr_n         (memr_n),
        .memw_n         (memw_n),
        .ior_n          (ior_n),
        .iow_n          (iow_n),
        .PriorityGen    (PriorityGen),
        .ldTempAddr     (ldTempAddr),
        .ldUpperAddress (ldUpperAddress),
        .ldLowerAddress (ldLowerAddress),
        .AddrGen        (AddrGen),
        .ldTempRegister (ldTempRegister),
        .eop_n          (eop_n),
        .svcCh          (svcCh)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0] mode;
        logic [1:0] ch;
        logic       rd;
        int         hldaN;     // hrq-high cycles before hlda answers
        int         tcOn;      // transfer number whose S4 sees TC (0 = never)
        int         carryOn;   // transfer number whose S4 sees carrypresent
        int         dropOn;    // transfer number whose S4 sees the request removed
        bit         hldaLoss;  // CPU takes hlda back when S1 is first seen
        int         expAg;
        int         expEop;
        int         expS1;
        int         expLat;    // cycles from PriorityGen to first read strobe
        int         expHrq;    // cycles with hrq high
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic runVec(input vec_t v, input int idx);
        int  ag = 0, eop = 0, s1 = 0, lat = -1, hrqCyc = 0, cyc = 0;
        int  badStrobe = 0, badDack = 0, hrqCnt = 0, xfer = 0;
        bit  started = 0, done = 0, hldaCut = 0;
        logic [3:0] expDack;
        expDack      = 4'b0001 << v.ch;
        transferMode = v.mode;
        isRead       = v.rd;
        channelNo    = v.ch;
        dmaReq       = expDack;
        hlda         = 1'b0;
        TC           = 1'b0;
        carrypresent = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (hrq) hrqCnt++;
            if (v.hldaLoss && adstb) hldaCut = 1;
            hlda = hrq && (hrqCnt >= v.hldaN) && !hldaCut;
            if (AddrGen) begin
                xfer++;
                TC           = (xfer == v.tcOn);
                carrypresent = (xfer == v.carryOn);
                if (xfer == v.dropOn) dmaReq = 4'b0000;
            end else begin
                TC           = 1'b0;
                carrypresent = 1'b0;
            end
            #1;
            if (PriorityGen && !started) begin
                started = 1;
                cyc     = 0;
            end
            if (started) begin
                if (AddrGen) ag++;
                if (!eop_n) eop++;
                if (adstb) begin
                    s1++;
                    if (dack !== expDack || aen !== 1'b1) badDack++;
                end
                if (lat < 0 && (!memr_n || !ior_n)) lat = cyc;
                if (hrq) hrqCyc++;
                if (v.rd ? (!memw_n || !ior_n) : (!memr_n || !iow_n)) badStrobe++;
                if (hrqCyc > 0 && !hrq) done = 1;
                cyc++;
            end
            @(posedge clk);
            #1;
            if (done) break;
        end
        check($sformatf("v%0d_done", idx), {31'd0, done}, 32'd1);
        check($sformatf("v%0d_addrgen", idx), ag, v.expAg);
        check($sformatf("v%0d_eop", idx), eop, v.expEop);
        check($sformatf("v%0d_s1", idx), s1, v.expS1);
        check($sformatf("v%0d_latency", idx), lat, v.expLat);
        check($sformatf("v%0d_hrqcycles", idx), hrqCyc, v.expHrq);
        check($sformatf("v%0d_dack", idx), badDack, 0);
        check($sformatf("v%0d_strobedir", idx), badStrobe, 0);
        $display("[TB] vec %0d mode=%0d ch=%0d ag=%0d eop=%0d s1=%0d lat=%0d hrqCyc=%0d",
                 idx, v.mode, v.ch, ag, eop, s1, lat, hrqCyc);
        dmaReq = 4'b0000;
        hlda   = 1'b0;
        @(posedge clk);
        #1;
        check($sformatf("v%0d_idle_hrq", idx), {31'd0, hrq}, 32'd0);
        check($sformatf("v%0d_idle_dack", idx), {28'd0, dack}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{2'b01, 2'd2, 1'b1, 3, 0, 0, 1, 1'b0, 1, 0, 1, 6, 7};
        vecs[1] = '{2'b10, 2'd0, 1'b0, 1, 3, 0, 3, 1'b0, 3, 1, 1, 4, 11};
        vecs[2] = '{2'b10, 2'd3, 1'b1, 2, 3, 2, 3, 1'b0, 3, 1, 2, 5, 13};
        vecs[3] = '{2'b00, 2'd0, 1'b0, 1, 0, 0, 2, 1'b0, 2, 0, 1, 4, 8};
        vecs[4] = '{2'b00, 2'd1, 1'b1, 2, 2, 1, 2, 1'b0, 2, 1, 2, 5, 10};
        vecs[5] = '{2'b01, 2'd3, 1'b0, 5, 0, 0, 1, 1'b0, 1, 0, 1, 8, 9};
        vecs[6] = '{2'b10, 2'd1, 1'b0, 1, 0, 0, 1, 1'b1, 1, 0, 1, 4, 5};

        rst          = 1'b0;
        dmaReq       = 4'b0000;
        channelNo    = 2'd0;
        hlda         = 1'b0;
        TC           = 1'b0;
        carrypresent = 1'b0;
        transferMode = 2'b00;
        isRead       = 1'b0;
        #1;
        check("rst_hrq", {31'd0, hrq}, 32'd0);
        check("rst_dack", {28'd0, dack}, 32'd0);
        check("rst_strobes", {28'd0, memr_n, memw_n, ior_n, iow_n}, 32'hf);
        check("rst_ctrl", {26'd0, aen, adstb, AddrGen, ldTempRegister, eop_n, PriorityGen}, 32'h2);
        check("rst_svcch", {30'd0, svcCh}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            runVec(vecs[i], i);
        end

        // Cascade on channel 1: only DACK and HRQ, released one cycle after the request drops.
        begin
            bit seen = 0;
            int badCasc = 0;
            transferMode = 2'b11;
            channelNo    = 2'd1;
            dmaReq       = 4'b0010;
            for (int k = 0; k < 20; k++) begin
                hlda = hrq;
                #1;
                if (dack == 4'b0010) begin
                    seen = 1;
                    break;
                end
                @(posedge clk);
                #1;
            end
            check("casc_enter", {31'd0, seen}, 32'd1);
            for (int k = 0; k < 4; k++) begin
                if (hrq !== 1'b1 || dack !== 4'b0010 || {memr_n, memw_n, ior_n, iow_n} !== 4'hf
                    || AddrGen !== 1'b0 || aen !== 1'b0) badCasc++;
                @(posedge clk);
                #1;
            end
            check("casc_hold", badCasc, 0);
            check("casc_svcch", {30'd0, svcCh}, 32'd1);
            dmaReq = 4'b0000;
            #1;
            check("casc_dropcycle_dack", {28'd0, dack}, 32'h2);
            @(posedge clk);
            #1;
            hlda = 1'b0;
            check("casc_release_dack", {28'd0, dack}, 32'd0);
            check("casc_release_hrq", {31'd0, hrq}, 32'd0);
            $display("[TB] cascade ch1 seen=%0d holdErrs=%0d", seen, badCasc);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset asserted mid-cycle during S3.
        begin
            bit inS3 = 0;
            transferMode = 2'b10;
            channelNo    = 2'd2;
            isRead       = 1'b1;
            dmaReq       = 4'b0100;
            for (int k = 0; k < 30; k++) begin
                hlda = hrq;
                #1;
                if (!memr_n && iow_n) begin
                    inS3 = 1;
                    break;
                end
                @(posedge clk);
                #1;
            end
            check("rst_s3_reached", {31'd0, inS3}, 32'd1);
            #1;
            rst    = 1'b0;
            dmaReq = 4'b0000;
            hlda   = 1'b0;
            #1;
            check("arst_hrq", {31'd0, hrq}, 32'd0);
            check("arst_dack_aen", {27'd0, dack, aen}, 32'd0);
            check("arst_strobes", {28'd0, memr_n, memw_n, ior_n, iow_n}, 32'hf);
            check("arst_eop", {31'd0, eop_n}, 32'd1);
            check("arst_svcch", {30'd0, svcCh}, 32'd0);
            @(posedge clk);
            @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk);
            #1;
            check("post_rst_hrq", {31'd0, hrq}, 32'd0);
            dmaReq    = 4'b0001;
            channelNo = 2'd0;
            #1;
            check("post_rst_prigen", {31'd0, PriorityGen}, 32'd1);
            @(posedge clk);
            #1;
            check("post_rst_s0_hrq", {31'd0, hrq}, 32'd1);
            $display("[TB] reset-in-S3 reached=%0d", inS3);
            rst    = 1'b0;
            dmaReq = 4'b0000;
            @(posedge clk);
            #1;
            rst = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
